// File: rtl/tile004_map_fetch.sv
// Tile-map fetch stage: holds a writable screen tile map, turns draw
// coordinates into tile-ROM addresses and returns the registered palette
// index aligned with its coordinates. A clear sequencer sweeps the map to 0.
module tile004_map_fetch #(
   parameter int unsigned TILE_LOG2 = 4,
   parameter int unsigned MAP_COLS  = 40,
   parameter int unsigned MAP_ROWS  = 30,
   parameter int unsigned TILE_ID_W = 4,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic [9:0]                       DrawX,
   input  logic [9:0]                       DrawY,
   input  logic                             pix_en,
   input  logic                             wr_en,
   input  logic [5:0]                       wr_col,
   input  logic [4:0]                       wr_row,
   input  logic [TILE_ID_W-1:0]             wr_tile,
   input  logic                             clear_req,
   output logic                             busy,
   output logic [TILE_ID_W+2*TILE_LOG2-1:0] rom_addr,
   input  logic [3:0]                       rom_data,
   output logic [3:0]                       index,
   output logic                             index_valid,
   output logic [9:0]                       outX,
   output logic [9:0]                       outY
);

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned COL_W     = 6;
   localparam int unsigned ROW_W     = 5;
   localparam int unsigned PIX_W     = 4;
   localparam int unsigned MAP_DEPTH = MAP_COLS * MAP_ROWS;
   localparam int unsigned MAP_AW    = $clog2(MAP_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   logic [TILE_ID_W-1:0] map_mem [MAP_DEPTH];

   state_t               state_q, state_d;
   logic [MAP_AW-1:0]    cnt_q, cnt_d;

   logic                 mem_we_c;
   logic [MAP_AW-1:0]    mem_waddr_c;
   logic [TILE_ID_W-1:0] mem_wdata_c;

   logic                 vis_c;
   logic [COL_W-1:0]     rd_col_c;
   logic [ROW_W-1:0]     rd_row_c;
   logic [MAP_AW-1:0]    rd_addr_c;
   logic                 wr_in_range_c;
   logic [MAP_AW-1:0]    wr_addr_c;
   logic [PIX_W-1:0]     rom_sel_c;

   logic [COORD_W-1:0]   x0, y0, x1, y1;
   logic                 vis0, vis1;
   logic [TILE_ID_W-1:0] map_q;
   logic                 pix_d1;
   logic [PIX_W-1:0]     rom_hold;

   // Address arithmetic for display reads and host writes
   assign vis_c         = (DrawX < COORD_W'(H_ACTIVE)) && (DrawY < COORD_W'(V_ACTIVE));
   assign rd_col_c      = COL_W'(DrawX >> TILE_LOG2);
   assign rd_row_c      = ROW_W'(DrawY >> TILE_LOG2);
   assign rd_addr_c     = MAP_AW'(rd_row_c) * MAP_AW'(MAP_COLS) + MAP_AW'(rd_col_c);
   assign wr_in_range_c = (wr_col < COL_W'(MAP_COLS)) && (wr_row < ROW_W'(MAP_ROWS));
   assign wr_addr_c     = MAP_AW'(wr_row) * MAP_AW'(MAP_COLS) + MAP_AW'(wr_col);

   // ROM address comes straight from the stage-0 registers so the
   // 1-cycle ROM returns data in time for the output stage
   assign rom_addr = {map_q, y0[TILE_LOG2-1:0], x0[TILE_LOG2-1:0]};

   // ROM data is only fresh the cycle after an advance; otherwise use the held copy
   assign rom_sel_c = pix_d1 ? rom_data : rom_hold;

   // Clear FSM state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d == ST_CLEAR);
      end
   end

   // Clear FSM next-state and sweep counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == MAP_AW'(MAP_DEPTH - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + MAP_AW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Map write port: host writes when idle, tile 0 sweep while clearing
   always_comb begin
      mem_we_c    = 1'b0;
      mem_waddr_c = '0;
      mem_wdata_c = '0;
      case (state_q)
         ST_IDLE: begin
            if (wr_en && wr_in_range_c) begin
               mem_we_c    = 1'b1;
               mem_waddr_c = wr_addr_c;
               mem_wdata_c = wr_tile;
            end
         end
         ST_CLEAR: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
         end
         default: mem_we_c = 1'b0;
      endcase
   end

   // Map RAM write (contents are not reset)
   always_ff @(posedge Clk) begin
      if (mem_we_c) begin
         map_mem[mem_waddr_c] <= mem_wdata_c;
      end
   end

   // Three-stage display pipeline, advancing on pix_en; map read is read-first
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x0          <= '0;
         y0          <= '0;
         vis0        <= 1'b0;
         map_q       <= '0;
         x1          <= '0;
         y1          <= '0;
         vis1        <= 1'b0;
         index       <= '0;
         index_valid <= 1'b0;
         outX        <= '0;
         outY        <= '0;
      end else if (pix_en) begin
         x0   <= DrawX;
         y0   <= DrawY;
         vis0 <= vis_c;
         if (vis_c) begin
            map_q <= map_mem[rd_addr_c];
         end
         x1          <= x0;
         y1          <= y0;
         vis1        <= vis0;
         index       <= vis1 ? rom_sel_c : '0;
         index_valid <= vis1;
         outX        <= x1;
         outY        <= y1;
      end
   end

   // Capture ROM data for the stage-1 pixel in case the pipeline stalls
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_d1   <= 1'b0;
         rom_hold <= '0;
      end else begin
         pix_d1 <= pix_en;
         if (pix_d1) begin
            rom_hold <= rom_data;
         end
      end
   end

endmodule

// File: tb/tb_tile004_map_fetch.sv
// Bench for tile004_map_fetch: randomized and directed traffic, a map/ROM
// reference model and a scoreboard monitor on the pix_en-qualified outputs.
module tb_tile004_map_fetch;

   localparam int NT = 1200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic        pix_en = 1'b0, wr_en = 1'b0, clear_req = 1'b0;
   logic [5:0]  wr_col = '0;
   logic [4:0]  wr_row = '0;
   logic [3:0]  wr_tile = '0;
   logic        busy;
   logic [11:0] rom_addr;
   logic [3:0]  rom_data = '0;
   logic [3:0]  index;
   logic        index_valid;
   logic [9:0]  outX, outY;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       v;
      logic [3:0] idx;
   } exp_t;

   logic [3:0] rom_mem [4096];
   logic [3:0] ref_map [NT];
   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   bit         model_busy = 1'b0;

   always #5 clk = ~clk;

   tile004_map_fetch dut (
      .Clk(clk), .Reset_n(rst_n), .DrawX(DrawX), .DrawY(DrawY), .pix_en(pix_en),
      .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_tile(wr_tile),
      .clear_req(clear_req), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
      .index(index), .index_valid(index_valid), .outX(outX), .outY(outY)
   );

   // Registered tile ROM, 1-cycle latency
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // Expected output for a pixel, from the current map contents
   function automatic exp_t expect_pix(input int x, input int y);
      exp_t e;
      int   tile;
      e.x = 10'(x);
      e.y = 10'(y);
      e.v = (x < 640) && (y < 480);
      e.idx = 4'd0;
      if (e.v) begin
         tile  = int'(ref_map[(y / 16) * 40 + (x / 16)]);
         e.idx = rom_mem[tile * 256 + (y % 16) * 16 + (x % 16)];
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; model updates after the read is recorded (read-first)
   task automatic step(input bit en, input int x, input int y, input bit we,
                       input int c, input int r, input int t, input bit clr);
      @(negedge clk);
      pix_en    = en;
      DrawX     = 10'(x);
      DrawY     = 10'(y);
      wr_en     = we;
      wr_col    = 6'(c);
      wr_row    = 5'(r);
      wr_tile   = 4'(t);
      clear_req = clr;
      if (en) sb_q.push_back(expect_pix(x, y));
      if (we && !model_busy && c < 40 && r < 30) ref_map[r * 40 + c] = 4'(t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pix(input int x, input int y);
      step(1, x, y, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int c, input int r, input int t);
      step(0, 0, 0, 1, c, r, t, 0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < NT; k++) wr(k % 40, k / 40, int'($urandom_range(0, 15)));
   endtask

   task automatic pix_tile(input int k);
      pix((k % 40) * 16 + int'($urandom_range(0, 15)), (k / 40) * 16 + int'($urandom_range(0, 15)));
   endtask

   // Scoreboard monitor: each pixel emerges on the third advance after its issue
   initial begin
      int   adv;
      exp_t e;
      adv = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            adv = 0;
         end else if (pix_en) begin
            adv++;
            if (adv >= 3) begin
               @(negedge clk);
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL scoreboard_underflow: output with no expected entry");
               end else begin
                  e = sb_q.pop_front();
                  if (index !== e.idx || index_valid !== e.v || outX !== e.x || outY !== e.y) begin
                     errors++;
                     $display("FAIL pixel: got idx=%0h v=%0b x=%0d y=%0d expected idx=%0h v=%0b x=%0d y=%0d",
                              index, index_valid, outX, outY, e.idx, e.v, e.x, e.y);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int old_t, bcnt, k, x, y, c, r;
      bit en, we;
      for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom);
      rom_mem[12'h545] = 4'hA;

      // Reset behaviour
      repeat (4) @(negedge clk);
      check("rst_index", 32'(index), 0);
      check("rst_valid", 32'(index_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);
      rst_n = 1'b1;
      idle(3);
      check("post_rst_valid", 32'(index_valid), 0);
      check("post_rst_outx", 32'(outX), 0);

      fill_random();

      // Map fetch: tile 5 at (2,1), pixel (37,20)
      wr(2, 1, 5);
      pix(37, 20);
      pix(37, 20);
      check("rom_addr_545", 32'(rom_addr), 32'h545);
      pix(37, 20);
      pix(37, 20);
      check("fetch_index", 32'(index), 32'hA);
      check("fetch_outx", 32'(outX), 37);
      check("fetch_outy", 32'(outY), 20);

      // Stall pattern
      for (int i = 0; i < 10; i++) begin
         en = (i % 5 == 0) || (i % 5 == 3) || (i % 5 == 4);
         step(en, 200 + i * 7, 50 + i * 3, 0, 0, 0, 0, 0);
      end
      pix(201, 60);
      idle(3);
      pix(300, 70);

      // Off-screen pixels
      pix(700, 100);
      pix(100, 480);
      pix(639, 480);
      pix(640, 0);

      // Out-of-range write: col 40 would alias onto (0,1) if not dropped
      wr(40, 0, int'(ref_map[40]) + 1);
      wr(0, 30, int'(ref_map[0]) + 1);
      pix(5, 20);
      pix(3, 2);
      // Last tile
      wr(39, 29, int'(ref_map[1199]) + 1);
      pix(639, 479);

      // Read/write collision: first read returns the old tile, next the new one
      old_t = int'(ref_map[6 * 40 + 6]);
      step(1, 100, 100, 1, 6, 6, old_t + 1, 0);
      pix(101, 100);

      // Random traffic with stalls, writes and collisions
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 9) < 7);
         x  = int'($urandom_range(0, 799));
         y  = int'($urandom_range(0, 524));
         we = ($urandom_range(0, 9) < 3);
         c  = int'($urandom_range(0, 47));
         r  = int'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            c = (x / 16) % 64;
            r = (y / 16) % 32;
         end
         step(en, x, y, we, c, r, int'($urandom_range(0, 15)), 0);
      end

      // Clear sweep: fill with 7, then clear; late write and clear_req are ignored
      for (k = 0; k < NT; k++) wr(k % 40, k / 40, 7);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("busy_before_clear", 32'(busy), 0);
      model_busy = 1'b1;
      bcnt = 0;
      for (int i = 1; i <= 3000; i++) begin
         if (i == 500) step(0, 0, 0, 1, 5, 5, 3, 0);
         else if (i == 600) step(0, 0, 0, 0, 0, 0, 0, 1);
         else idle(1);
         if (busy === 1'b1) bcnt++;
         else break;
      end
      check("clear_busy_cycles", 32'(bcnt), 1200);
      model_busy = 1'b0;
      for (int i = 0; i < NT; i++) ref_map[i] = 4'd0;
      for (k = 0; k < NT; k++) pix_tile(k);

      // Reset mid-clear: no resume, partial clear retained
      fill_random();
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(300);
      @(negedge clk);
      rst_n     = 1'b0;
      pix_en    = 1'b0;
      wr_en     = 1'b0;
      clear_req = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      check("midclear_rst_busy", 32'(busy), 0);
      check("midclear_rst_valid", 32'(index_valid), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 250; i++) ref_map[i] = 4'd0;
      idle(3);
      check("no_resume_busy", 32'(busy), 0);
      pix_tile(0);
      pix_tile(100);
      pix_tile(249);
      pix_tile(1100);
      pix(639, 479);
      pix(700, 0);
      pix(700, 0);
      idle(2);
      check("scoreboard_inflight", 32'(sb_q.size()), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile004_map_fetch.md
Name: tile004_map_fetch

Overview:
- Upstream pixel-index stage for the 16-entry tile palette lookup.
- Holds a writable tile map covering the visible screen and translates VGA draw coordinates into tile-ROM addresses.
- Returns the 4-bit palette index from the tile ROM, registered and aligned with its coordinates; the palette stage consumes that index.
- Includes a clear sequencer that sweeps the whole map to tile 0.

Parameters:
- TILE_LOG2, 4, log2 of tile edge in pixels (16x16 tiles)
- MAP_COLS, 40, tiles per row
- MAP_ROWS, 30, tile rows
- TILE_ID_W, 4, tile ID width (16 tile types)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines

Ports:
- Clk  in  1  system/pixel clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pix_en  in  1  pixel strobe; pipeline advances only when high
- wr_en  in  1  map write request
- wr_col  in  6  map column, valid range 0..MAP_COLS-1
- wr_row  in  5  map row, valid range 0..MAP_ROWS-1
- wr_tile  in  TILE_ID_W  tile ID to store
- clear_req  in  1  pulse; starts a full-map clear
- busy  out  1  clear sweep in progress
- rom_addr  out  TILE_ID_W+2*TILE_LOG2  tile-ROM address = {tile_id, y[3:0], x[3:0]}
- rom_data  in  4  tile-ROM pixel; registered ROM, 1-cycle latency
- index  out  4  palette index for the palette stage
- index_valid  out  1  index belongs to a visible pixel
- outX  out  10  DrawX aligned with index
- outY  out  10  DrawY aligned with index

Behaviour:
- Reset (async, Reset_n low): index, index_valid, outX, outY, rom_addr, busy and all pipeline registers = 0; FSM -> IDLE. Map RAM contents are not reset.
- Map storage: MAP_COLS*MAP_ROWS x TILE_ID_W RAM, address = row*MAP_COLS + col.
  - Synchronous read-first: a same-cycle write and read to one address returns the old data.
- Pipeline, advancing only on cycles with pix_en=1; registers hold otherwise:
  - S0: latch DrawX/DrawY. vis = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE). Issue map read at (DrawY>>4)*MAP_COLS + (DrawX>>4).
  - S1: map data available; drive rom_addr = {tile_id, Y[3:0], X[3:0]}; carry X, Y, vis.
  - S2: rom_data available; index <= vis ? rom_data : 0; index_valid <= vis; outX/outY <= carried coords.
- Latency: 3 pix_en-qualified cycles from DrawX/DrawY to index.
- Off-screen pixels: no map read is issued (address held); index=0, index_valid=0.
- Writes, IDLE state:
  - wr_en=1 with wr_col < MAP_COLS and wr_row < MAP_ROWS writes wr_tile in one cycle.
  - Out-of-range coordinates: write dropped silently.
  - Writes do not depend on pix_en.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req=1; address counter = 0, busy=1 from the next cycle.
  - CLEAR: write tile 0 at counter; counter +1 each cycle.
  - At counter = MAP_COLS*MAP_ROWS-1: write, then -> IDLE with busy=0. Total 1200 cycles with busy=1.
  - wr_en during CLEAR: ignored.
  - clear_req during CLEAR: ignored (no restart).
  - Display reads continue during CLEAR and may return old or cleared tiles.
- Simultaneous clear_req and wr_en in IDLE: the write is performed this cycle, and CLEAR begins next cycle.
- Reset asserted mid-CLEAR: FSM -> IDLE, busy=0. Partially cleared map is retained; no resume.
- Width rules:
  - Tile row = DrawY[9:4] truncated to 5 bits, used only when vis=1.
  - Map address width = ceil(log2(MAP_COLS*MAP_ROWS)) = 11.

Test Plan:
- Reset: hold Reset_n=0 with Clk running -> index=0, index_valid=0, busy=0, rom_addr=0. Release -> stays 0 until the first pix_en.
- Map fetch: write tile 5 at (col 2, row 1); drive DrawX=37, DrawY=20, pix_en=1 continuously -> 2 cycles later rom_addr=0x545. With the ROM model returning 0xA, index=0xA, index_valid=1, outX=37, outY=20, exactly 3 cycles after input.
- Stall: toggle pix_en 1,0,0,1,1 across a coordinate sweep -> outputs change only on pix_en cycles; coordinate/index pairing is preserved.
- Off-screen: DrawX=700, DrawY=100 -> index=0, index_valid=0. DrawY=480 with any X -> index_valid=0.
- Clear: fill the map with tile 7; pulse clear_req -> busy high for exactly 1200 cycles; wr_en at cycle 500 is ignored. Afterwards every map location reads tile 0 (rom_addr[11:8]=0).
- Boundary write/collision:
  - Write at col 40 -> dropped.
  - Write to (39,29) -> stored; pixel (639,479) shows the new tile.
  - A write in the same cycle as a read of the same address -> that read returns the old tile; the next read returns the new one.
